// File: rtl/mux_rr_arbiter_if.sv
// Handshake bundle for mux_rr_arbiter.
// Requester side: in_data (4 packed words), in_valid, in_ready (one-hot accept).
// Consumer side:  out_data, out_sel, out_valid, out_ready.
// The slave modport is the arbiter; the master modport is the producers/consumer environment.
interface mux_rr_arbiter_if #(
    parameter int unsigned Width = 32
);
    logic [4*Width-1:0] in_data;
    logic [3:0]         in_valid;
    logic [3:0]         in_ready;
    logic [Width-1:0]   out_data;
    logic [1:0]         out_sel;
    logic               out_valid;
    logic               out_ready;

    modport master (
        output in_data,
        output in_valid,
        output out_ready,
        input  in_ready,
        input  out_data,
        input  out_sel,
        input  out_valid
    );

    modport slave (
        input  in_data,
        input  in_valid,
        input  out_ready,
        output in_ready,
        output out_data,
        output out_sel,
        output out_valid
    );
endinterface

// File: rtl/mux_rr_arbiter.sv
// 4-requester round-robin arbiter feeding a 4:1 data mux and a single-entry output register.
// Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset
//   lock   - (only with ARB_LOCK_EN) burst lock: lock[ptr] keeps the last winner granted
//   bus    - mux_rr_arbiter_if.slave: in_data/in_valid/in_ready, out_data/out_sel/out_valid/out_ready
// Optional feature macro: ARB_LOCK_EN (undefined: pure round-robin, no lock port).
// in_ready is combinational from in_valid, out_ready and the slot state.
module mux_rr_arbiter #(
    parameter int unsigned Width = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
`ifdef ARB_LOCK_EN
    input  logic [3:0]            lock,
`endif
    mux_rr_arbiter_if.slave       bus
);

    localparam int unsigned NumReq = 4;
    localparam int unsigned IdxW   = 2;

    logic [IdxW-1:0]   ptr;
    logic [Width-1:0]  out_data_q;
    logic [IdxW-1:0]   out_sel_q;
    logic              out_valid_q;

    logic              free_c;
    logic              found_c;
    logic [IdxW-1:0]   win_c;
    logic [IdxW-1:0]   idx_c;
    logic              xfer_c;
    logic [NumReq-1:0] in_ready_c;
    logic [Width-1:0]  sel_data_c;

    // Slot can take a word when empty or when the current word drains this cycle.
    assign free_c = !out_valid_q || bus.out_ready;

    // Round-robin search starting after ptr; ptr itself is checked last.
    always_comb begin
        found_c = 1'b0;
        win_c   = '0;
        idx_c   = '0;
        for (int unsigned k = 1; k <= NumReq; k++) begin
            idx_c = ptr + IdxW'(k);
            if (!found_c && bus.in_valid[idx_c]) begin
                found_c = 1'b1;
                win_c   = idx_c;
            end
        end
`ifdef ARB_LOCK_EN
        // Burst lock: the previous winner keeps the grant while it locks and stays valid.
        if (lock[ptr] && bus.in_valid[ptr]) begin
            found_c = 1'b1;
            win_c   = ptr;
        end
`endif
    end

    // One-hot accept; held low during reset.
    always_comb begin
        xfer_c     = rst_n && free_c && found_c;
        in_ready_c = '0;
        if (xfer_c) begin
            in_ready_c[win_c] = 1'b1;
        end
    end

    // 4:1 data mux on the winner index.
    always_comb begin
        sel_data_c = '0;
        for (int unsigned i = 0; i < NumReq; i++) begin
            if (win_c == IdxW'(i)) begin
                sel_data_c = bus.in_data[i*Width +: Width];
            end
        end
    end

    // Output stage and last-grant pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_q  <= '0;
            out_sel_q   <= '0;
            out_valid_q <= 1'b0;
            ptr         <= IdxW'(NumReq - 1);
        end else if (xfer_c) begin
            out_data_q  <= sel_data_c;
            out_sel_q   <= win_c;
            out_valid_q <= 1'b1;
            ptr         <= win_c;
        end else if (free_c) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_data  = out_data_q;
    assign bus.out_sel   = out_sel_q;
    assign bus.out_valid = out_valid_q;

endmodule
